// File: rtl/ad_bus_arb_pkg.sv
// Shared types and defaults for the AD register-bus arbiter.
package ad_bus_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    localparam int TIMEOUT_DEFAULT = 2000000;

endpackage

// File: rtl/ad_bus_arb_rr_pick.sv
// Round-robin winner selection: the first set request at or after last_gnt+1.
module rr_pick #(
    parameter int NREQ = 3,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_gnt,
    output logic [NREQ-1:0] win
);

    // Scan from the farthest offset down so the nearest requester overwrites.
    always_comb begin
        win = '0;
        for (int unsigned i = NREQ; i >= 1; i--) begin
            if (req[(32'(last_gnt) + i) % NREQ]) begin
                win = NREQ'(1) << ((32'(last_gnt) + i) % NREQ);
            end
        end
    end

endmodule

// File: rtl/ad_bus_arb.sv
// Shares the AD-chip register-access port among NREQ requesters with
// round-robin arbitration, burst locking until last, and a response timeout.
module ad_bus_arb
    import ad_bus_arb_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   rq_req,
    input  logic [NREQ-1:0]   rq_wr,
    input  logic [NREQ-1:0]   rq_last,
    input  logic [8*NREQ-1:0] rq_addr,
    input  logic [8*NREQ-1:0] rq_wrdata,
    output logic [NREQ-1:0]   rq_ack,
    output logic [NREQ-1:0]   rq_err,
    output logic [7:0]        rq_rddata,
    output logic [NREQ-1:0]   gnt,
    output logic [7:0]        adaddr,
    output logic [7:0]        adwrdata,
    output logic              adreq,
    output logic              adwr,
    output logic              adlast,
    input  logic [7:0]        adrddata,
    input  logic              adack,
    input  logic              aderr,
    output logic [7:0]        tmo_cnt
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t      state, state_next;
    logic [IW-1:0]   g_idx, last_gnt, pick_idx;
    logic [NREQ-1:0] pick;
    logic [CW-1:0]   to_cnt;
    logic            ev_ack, ev_done, ev_tmo;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req      (rq_req),
        .last_gnt (last_gnt),
        .win      (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick[i]) pick_idx = IW'(i);
        end
    end

    assign rq_rddata = adrddata;

    // Error beats ack; abort and timeout only apply when the bus is silent.
    always_comb begin
        state_next = state;
        adaddr     = '0;
        adwrdata   = '0;
        adreq      = 1'b0;
        adwr       = 1'b0;
        adlast     = 1'b1;
        rq_ack     = '0;
        rq_err     = '0;
        ev_ack     = 1'b0;
        ev_done    = 1'b0;
        ev_tmo     = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (|rq_req) state_next = ARB_GRANT;
            end
            ARB_GRANT: begin
                adaddr   = rq_addr[32'(g_idx)*8 +: 8];
                adwrdata = rq_wrdata[32'(g_idx)*8 +: 8];
                adreq    = rq_req[g_idx];
                adwr     = rq_wr[g_idx];
                adlast   = rq_last[g_idx];
                if (aderr) begin
                    rq_err[g_idx] = 1'b1;
                    ev_done       = 1'b1;
                end else if (adack) begin
                    rq_ack[g_idx] = 1'b1;
                    ev_ack        = 1'b1;
                    ev_done       = rq_last[g_idx];
                end else if (!rq_req[g_idx]) begin
                    state_next = ARB_IDLE;
                end else if (to_cnt == CW'(TIMEOUT - 1)) begin
                    rq_err[g_idx] = 1'b1;
                    ev_tmo        = 1'b1;
                    ev_done       = 1'b1;
                end
                if (ev_done) state_next = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ARB_IDLE;
            gnt      <= '0;
            g_idx    <= '0;
            last_gnt <= IW'(NREQ - 1);
            to_cnt   <= '0;
            tmo_cnt  <= '0;
        end else begin
            state <= state_next;
            if (state == ARB_IDLE) begin
                if (state_next == ARB_GRANT) begin
                    gnt    <= pick;
                    g_idx  <= pick_idx;
                    to_cnt <= '0;
                end
            end else begin
                if (state_next == ARB_IDLE) gnt <= '0;
                if (ev_done) last_gnt <= g_idx;
                if (ev_ack) to_cnt <= '0;
                else if (adreq) to_cnt <= to_cnt + CW'(1);
                if (ev_tmo && tmo_cnt != '1) tmo_cnt <= tmo_cnt + 8'd1;
            end
        end
    end

endmodule
